spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter READ_WAIT, default 2: idle SPI clocks between the last command bit and the first MISO sample of a read-data frame.
REQ-002 Parameter SS_IDLE, default 1: minimum cycles SS_n is held high between frames.
REQ-003 clk  in  1  single system clock; all logic on rising edge; serial bit rate equals clk rate.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  host presents a 10-bit SPI command.
REQ-006 cmd_ready  out  1  block can accept a command this cycle.
REQ-007 cmd_data  in  10  command word: [9:8] opcode (00 write-addr, 01 write-data, 10 read-addr, 11 read-data), [7:0] payload.
REQ-008 rx_valid  out  1  one-cycle pulse, rx_data valid.
REQ-009 rx_data  out  8  byte returned by slave on a read-data frame.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 SS_n  out  1  active-low slave select to the SPI slave/RAM wrapper.
REQ-012 MOSI  out  1  serial command to slave.
REQ-013 MISO  in  1  serial read data from slave.

Function
REQ-014 States SHALL be IDLE, START, SHIFT, WAIT_RD, CAPTURE, END.
REQ-015 IDLE: SS_n=1, MOSI=0, cmd_ready=1; on cmd_valid&&cmd_ready, latch cmd_data and go to START.
REQ-016 cmd_ready SHALL be 0 in every state except IDLE; commands offered while busy are ignored (not queued).
REQ-017 START: one cycle, SS_n=0, MOSI=0 (slave command-check cycle); then SHIFT.
REQ-018 SHIFT: exactly 10 cycles, SS_n=0, cycle k (0..9) drives MOSI=cmd[9-k], MSB first, bit counter 4 bits, 0..9 without wrap.
REQ-019 After SHIFT bit 9: opcode!=11 -> END; opcode==11 -> WAIT_RD.
REQ-020 WAIT_RD: READ_WAIT cycles, SS_n=0, MOSI=0; READ_WAIT=0 goes directly to CAPTURE.
REQ-021 CAPTURE: exactly 8 cycles, SS_n=0, MOSI=0, MISO sampled each rising edge into a shift register, first sample = rx_data[7].
REQ-022 rx_valid SHALL pulse high for exactly one cycle, the cycle after the 8th sample, with rx_data stable; rx_data holds its value until the next read-data completion.
REQ-023 END: SS_n=1, MOSI=0 for SS_IDLE cycles (minimum 1 even if SS_IDLE=0), then IDLE.
REQ-024 Minimum frame length: write/addr = 1+10+SS_IDLE cycles; read-data = 1+10+READ_WAIT+8+SS_IDLE cycles, plus one IDLE cycle for acceptance.
REQ-025 Back-to-back: cmd_valid held high SHALL be accepted on the first IDLE cycle after END; SS_n SHALL never stay low across two frames.
REQ-026 MISO value X/Z during CAPTURE SHALL be captured as-is; no sampling of MISO outside CAPTURE.
REQ-027 All outputs SHALL be registered (no combinational path from cmd_valid or MISO to any output).

Reset
REQ-028 rst high at a clock edge SHALL force IDLE, SS_n=1, MOSI=0, cmd_ready=1 after reset deasserts (0 while rst high), busy=0, rx_valid=0, rx_data=8'h00, counters 0.
REQ-029 Reset mid-frame (any state) SHALL abort: SS_n=1 the cycle after, no rx_valid for the aborted frame, latched command discarded.
REQ-030 rst and cmd_valid in the same cycle: reset wins, command not accepted.

Verification
REQ-031 Write-addr: cmd 10'h0FF -> SS_n low 11 cycles, MOSI after START = 0,0,1,1,1,1,1,1,1,1; no rx_valid.
REQ-032 Full RAM round trip with SPI wrapper/RAM model: 10'h0FF, 10'h1CF, 10'h2FF, 10'h311 -> one rx_valid, rx_data=8'hCF.
REQ-033 Read-data with MISO model driving 8'hA5 MSB first after READ_WAIT=2 -> rx_data=8'hA5, rx_valid exactly 1 cycle, 22 cycles after acceptance (1+10+2+8+1).
REQ-034 cmd_valid held high with 3 queued commands -> each accepted only in IDLE, SS_n high ≥SS_IDLE cycles between frames, cmd_ready=0 throughout frames.
REQ-035 rst asserted during CAPTURE bit 4 -> next cycle SS_n=1, busy=0, no rx_valid, rx_data=8'h00; subsequent 10'h311 completes normally.
REQ-036 READ_WAIT=0, SS_IDLE=0 build: read-data frame completes in 20 cycles from acceptance, SS_n high 1 cycle between frames.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: 10-bit command shifter with read-data capture
module spi_master_ctrl #(
    parameter int unsigned READ_WAIT = 2,
    parameter int unsigned SS_IDLE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        WAIT_RD,
        CAPTURE,
        END
    } state_t;

    // END always lasts at least one cycle so SS_n is seen high between frames
    localparam int unsigned END_CYCLES = (SS_IDLE == 0) ? 1 : SS_IDLE;
    localparam logic [15:0] WAIT_LAST  = (READ_WAIT == 0) ? 16'd0 : 16'(READ_WAIT - 1);
    localparam logic [15:0] END_LAST   = 16'(END_CYCLES - 1);

    state_t      state_q, state_d;
    logic [9:0]  cmd_q, cmd_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_q, cmd_ready_d;

    // Next-state, counters, command latch and MISO capture
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d  = 4'd0;
                wait_cnt_d = 16'd0;
                if (cmd_valid) begin
                    cmd_d   = cmd_data;
                    state_d = START;
                end
            end
            START: begin
                bit_cnt_d = 4'd0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q == 4'd9) begin
                    bit_cnt_d  = 4'd0;
                    wait_cnt_d = 16'd0;
                    if (cmd_q[9:8] == 2'b11) begin
                        state_d = (READ_WAIT == 0) ? CAPTURE : WAIT_RD;
                    end else begin
                        state_d = END;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            WAIT_RD: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 16'd0;
                    bit_cnt_d  = 4'd0;
                    state_d    = CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            CAPTURE: begin
                shift_d = {shift_q[6:0], MISO};
                if (bit_cnt_q == 4'd7) begin
                    rx_data_d  = shift_d;
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = 4'd0;
                    wait_cnt_d = 16'd0;
                    state_d    = END;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            END: begin
                if (wait_cnt_q == END_LAST) begin
                    wait_cnt_d = 16'd0;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, so registered outputs line up with it
    always_comb begin
        ss_n_d      = (state_d == IDLE) || (state_d == END);
        mosi_d      = (state_d == SHIFT) ? cmd_d[4'd9 - bit_cnt_d] : 1'b0;
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= 10'd0;
            bit_cnt_q   <= 4'd0;
            wait_cnt_q  <= 16'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // cmd_ready is held low while reset is asserted
    assign cmd_ready = cmd_ready_q & ~rst;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - randomized self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

    localparam int RW0 = 2;
    localparam int SSI0 = 1;
    localparam int RW1 = 0;
    localparam int SSI1 = 0;

    logic       clk;
    logic       rst;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [9:0] cmd_data  [2];
    logic       rx_valid  [2];
    logic [7:0] rx_data   [2];
    logic       busy      [2];
    logic       ss_n      [2];
    logic       mosi      [2];
    logic       miso      [2];
    logic [7:0] exp_rx    [2];

    int errors = 0;
    int checks = 0;

    spi_master_ctrl #(.READ_WAIT(RW0), .SS_IDLE(SSI0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_data(cmd_data[0]), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
        .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_master_ctrl #(.READ_WAIT(RW1), .SS_IDLE(SSI1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_data(cmd_data[1]), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
        .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Offers cmd to DUT d, then checks every cycle of the frame against a timeline
    // built from the frame-length rules. Called just after a negedge; returns just
    // after the negedge of the first IDLE cycle following the frame.
    task automatic run_frame(input int d, input logic [9:0] cmd, input logic [7:0] mbyte,
                             input bit hold, output int waited);
        int  rw, endlen, len, cap0;
        bit  rd;
        logic exp_ss, exp_mosi, exp_rv;
        rw     = (d == 0) ? RW0 : RW1;
        endlen = (d == 0) ? SSI0 : SSI1;
        if (endlen < 1) endlen = 1;
        rd     = (cmd[9:8] == 2'b11);
        len    = 11 + (rd ? (rw + 8) : 0) + endlen;
        cap0   = 12 + rw;
        cmd_valid[d] = 1'b1;
        cmd_data[d]  = cmd;
        waited = 0;
        while (cmd_ready[d] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (cmd_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout d=%0d cmd_ready=%b exp=1", d, cmd_ready[d]);
            cmd_valid[d] = 1'b0;
            return;
        end
        if (rd) exp_rx[d] = mbyte;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            exp_ss   = (c > len - endlen);
            exp_mosi = (c >= 2 && c <= 11) ? cmd[11 - c] : 1'b0;
            exp_rv   = rd && (c == cap0 + 8);
            checks++;
            if (ss_n[d] !== exp_ss) begin
                errors++;
                $display("FAIL ss_n d=%0d cmd=%h c=%0d got=%b exp=%b", d, cmd, c, ss_n[d], exp_ss);
            end
            checks++;
            if (mosi[d] !== exp_mosi) begin
                errors++;
                $display("FAIL mosi d=%0d cmd=%h c=%0d got=%b exp=%b", d, cmd, c, mosi[d], exp_mosi);
            end
            checks++;
            if (busy[d] !== 1'b1 || cmd_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready d=%0d c=%0d got busy=%b ready=%b exp busy=1 ready=0",
                         d, c, busy[d], cmd_ready[d]);
            end
            checks++;
            if (rx_valid[d] !== exp_rv) begin
                errors++;
                $display("FAIL rx_valid d=%0d cmd=%h c=%0d got=%b exp=%b", d, cmd, c, rx_valid[d], exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rx_data[d] !== mbyte) begin
                    errors++;
                    $display("FAIL rx_data d=%0d c=%0d got=%h exp=%h", d, c, rx_data[d], mbyte);
                end
            end
            cmd_valid[d] = hold;
            cmd_data[d]  = 10'($urandom);
            if (rd && c >= cap0 && c < cap0 + 8) miso[d] = mbyte[7 - (c - cap0)];
            else miso[d] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        checks++;
        if (ss_n[d] !== 1'b1 || busy[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || rx_valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after d=%0d got ss_n=%b busy=%b ready=%b rv=%b exp 1 0 1 0",
                     d, ss_n[d], busy[d], cmd_ready[d], rx_valid[d]);
        end
        checks++;
        if (rx_data[d] !== exp_rx[d]) begin
            errors++;
            $display("FAIL rx_hold d=%0d got=%h exp=%h", d, rx_data[d], exp_rx[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_data[d]  = 10'd0;
            miso[d]      = 1'b0;
            exp_rx[d]    = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ss_n[d] !== 1'b1 || mosi[d] !== 1'b0 || busy[d] !== 1'b0 || rx_valid[d] !== 1'b0
                || rx_data[d] !== 8'h00 || cmd_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state d=%0d got ss=%b mosi=%b busy=%b rv=%b rx=%h ready=%b exp 1 0 0 0 00 0",
                         d, ss_n[d], mosi[d], busy[d], rx_valid[d], rx_data[d], cmd_ready[d]);
            end
        end
        cmd_valid[0] = 1'b1;
        cmd_data[0]  = 10'h311;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || ss_n[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release d=%0d got busy=%b ready=%b ss=%b exp 0 1 1",
                         d, busy[d], cmd_ready[d], ss_n[d]);
            end
        end
    endtask

    task automatic test_write_addr();
        int w;
        run_frame(0, 10'h0FF, 8'h00, 1'b0, w);
    endtask

    task automatic test_read_a5();
        int w;
        run_frame(0, 10'h3C4, 8'hA5, 1'b0, w);
    endtask

    task automatic test_ram_round_trip();
        logic [7:0] ram [256];
        logic [7:0] addr;
        logic [9:0] seq [4];
        logic [7:0] mb;
        int w;
        seq[0] = 10'h0FF; seq[1] = 10'h1CF; seq[2] = 10'h2FF; seq[3] = 10'h311;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            mb = 8'h00;
            case (seq[i][9:8])
                2'b00, 2'b10: addr = seq[i][7:0];
                2'b01: ram[addr] = seq[i][7:0];
                default: mb = ram[addr];
            endcase
            run_frame(0, seq[i], mb, 1'b0, w);
        end
        checks++;
        if (rx_data[0] !== 8'hCF) begin
            errors++;
            $display("FAIL ram_round_trip got=%h exp=cf", rx_data[0]);
        end
    endtask

    task automatic test_random();
        int w;
        bit h;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                h = (i != 11) ? 1'($urandom_range(0, 1)) : 1'b0;
                run_frame(d, 10'($urandom), 8'($urandom), h, w);
            end
            cmd_valid[d] = 1'b0;
        end
    endtask

    task automatic test_back_to_back(input int d);
        int w;
        logic [9:0] c;
        for (int i = 0; i < 3; i++) begin
            c = (i == 1) ? {2'b11, 8'($urandom)} : 10'($urandom_range(0, 767));
            run_frame(d, c, 8'($urandom), (i < 2), w);
            if (i > 0) begin
                checks++;
                if (w != 0) begin
                    errors++;
                    $display("FAIL back_to_back d=%0d frame=%0d waited=%0d exp=0", d, i, w);
                end
            end
        end
        cmd_valid[d] = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int w;
        int seen;
        cmd_valid[0] = 1'b1;
        cmd_data[0]  = 10'h311;
        w = 0;
        while (cmd_ready[0] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            cmd_valid[0] = 1'b0;
            miso[0] = 1'($urandom_range(0, 1));
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ss_n[0] !== 1'b1 || busy[0] !== 1'b0 || rx_valid[0] !== 1'b0 || rx_data[0] !== 8'h00) begin
            errors++;
            $display("FAIL midframe_reset got ss=%b busy=%b rv=%b rx=%h exp 1 0 0 00",
                     ss_n[0], busy[0], rx_valid[0], rx_data[0]);
        end
        rst = 1'b0;
        exp_rx[0] = 8'h00;
        exp_rx[1] = 8'h00;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (rx_valid[0] !== 1'b0 || busy[0] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL aborted_frame_activity got=%0d exp=0", seen);
        end
        run_frame(0, 10'h311, 8'($urandom), 1'b0, w);
    endtask

    task automatic test_zero_wait();
        int w;
        run_frame(1, {2'b11, 8'($urandom)}, 8'h5A, 1'b0, w);
        test_back_to_back(1);
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_read_a5();
        test_ram_round_trip();
        test_back_to_back(0);
        test_random();
        test_reset_midframe();
        test_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
